// File: rtl/stack_counter_reg_pkg.sv
// Shared definitions for the counter register: register-op priority encoding
// and stack sizing helpers.
package stack_counter_reg_pkg;

   // Register-update sources, encoded lowest to highest priority
   typedef enum logic [2:0] {
      OP_HOLD  = 3'd0,
      OP_CLEAR = 3'd1,
      OP_DEC   = 3'd2,
      OP_INC   = 3'd3,
      OP_LOAD  = 3'd4,
      OP_POP   = 3'd5
   } reg_op_e;

   function automatic int stk_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int stk_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/stack_counter_reg_lifo_stack.sv
// WIDTH x DEPTH LIFO with entry count. The caller guarantees push/pop/xchg are
// only asserted when legal and are mutually exclusive.
module lifo_stack
   import stack_counter_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  logic                          i_xchg,
   input  logic [WIDTH-1:0]              i_wdata,
   output logic [WIDTH-1:0]              o_top,
   output logic [stk_cnt_w(DEPTH)-1:0]   o_count,
   output logic                          o_full,
   output logic                          o_empty
);

   localparam int CW = stk_cnt_w(DEPTH);
   localparam int AW = stk_idx_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_top_cnt;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_top_idx;

   assign w_top_cnt = r_count - CW'(1);
   assign w_wr_idx  = AW'(r_count);
   assign w_top_idx = AW'(w_top_cnt);

   // Storage is never cleared; a reset only forgets the entries via the count
   always_ff @(posedge clk) begin
      if (!rst && i_push)
         r_mem[w_wr_idx] <= i_wdata;
      else if (!rst && i_xchg)
         r_mem[w_top_idx] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (i_push)
         r_count <= r_count + CW'(1);
      else if (i_pop)
         r_count <= w_top_cnt;
   end

   assign o_top   = r_mem[w_top_idx];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/stack_counter_reg.sv
// Load/step/clear counter register with wrap or saturate arithmetic and a
// save/restore LIFO for call/return style use.
module stack_counter_reg
   import stack_counter_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter int               STEP      = 1,
   parameter int               SATURATE  = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic                          inc,
   input  logic                          dec,
   input  logic                          clear,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              regInput,
   output logic [WIDTH-1:0]              regOutput,
   output logic [stk_cnt_w(DEPTH)-1:0]   stkCount,
   output logic                          stkFull,
   output logic                          stkEmpty,
   output logic                          carry,
   output logic                          err
);

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] r_reg;
   logic             r_carry;
   logic             r_err;

   logic             w_full, w_empty;
   logic [WIDTH-1:0] w_top;
   logic             w_push_en, w_pop_en, w_xchg_en, w_err_set;
   logic [WIDTH:0]   w_sum, w_diff;
   logic [WIDTH-1:0] w_inc_val, w_dec_val, w_reg_nxt;
   logic             w_inc_cy, w_dec_cy, w_carry_nxt;
   reg_op_e          w_op;

   // push+pop on an empty stack degrades to a plain push (flagged as an error)
   assign w_push_en = push && ((!pop && !w_full) || (pop && w_empty));
   assign w_pop_en  = pop && !push && !w_empty;
   assign w_xchg_en = push && pop && !w_empty;
   assign w_err_set = (push && !pop && w_full) || (pop && w_empty);

   lifo_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_en),
      .i_pop   (w_pop_en),
      .i_xchg  (w_xchg_en),
      .i_wdata (r_reg),
      .o_top   (w_top),
      .o_count (stkCount),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_sum  = {1'b0, r_reg} + STEP_X;
   assign w_diff = {1'b0, r_reg} - STEP_X;

   always_comb begin
      w_inc_cy  = w_sum[WIDTH];
      w_dec_cy  = w_diff[WIDTH];
      w_inc_val = w_sum[WIDTH-1:0];
      w_dec_val = w_diff[WIDTH-1:0];
      if (SATURATE != 0) begin
         if (w_inc_cy) w_inc_val = '1;
         if (w_dec_cy) w_dec_val = '0;
      end
   end

   always_comb begin
      w_op = OP_HOLD;
      if (w_pop_en || w_xchg_en) w_op = OP_POP;
      else if (load)             w_op = OP_LOAD;
      else if (inc)              w_op = OP_INC;
      else if (dec)              w_op = OP_DEC;
      else if (clear)            w_op = OP_CLEAR;
   end

   always_comb begin
      w_reg_nxt   = r_reg;
      w_carry_nxt = 1'b0;
      case (w_op)
         OP_POP:   w_reg_nxt = w_top;
         OP_LOAD:  w_reg_nxt = regInput;
         OP_INC:   begin w_reg_nxt = w_inc_val; w_carry_nxt = w_inc_cy; end
         OP_DEC:   begin w_reg_nxt = w_dec_val; w_carry_nxt = w_dec_cy; end
         OP_CLEAR: w_reg_nxt = '0;
         default:  w_reg_nxt = r_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg   <= RESET_VAL;
         r_carry <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_reg   <= w_reg_nxt;
         r_carry <= w_carry_nxt;
         if (w_err_set)  r_err <= 1'b1;
         else if (clear) r_err <= 1'b0;
      end
   end

   assign regOutput = r_reg;
   assign stkFull   = w_full;
   assign stkEmpty  = w_empty;
   assign carry     = r_carry;
   assign err       = r_err;

endmodule
